// File: rtl/rotation_amount_finder_pkg.sv
// Shared definitions for the rotation-amount finder: FSM encoding and the
// rotation direction constants (same encoding as the barrel shifter).
package rotation_amount_finder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rotation_amount_finder_rotate_one_bit.sv
// Combinational single-step rotator: rotates an N-bit word by one position
// in the requested direction.
module rotate_one_bit
  import rotation_amount_finder_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] din,
  input  logic         dir,
  output logic [N-1:0] dout
);

  // Left moves the MSB into bit 0; right moves bit 0 into the MSB.
  always_comb begin
    if (dir == DIR_LEFT) begin
      dout = {din[N-2:0], din[N-1]};
    end else begin
      dout = {din[0], din[N-1:1]};
    end
  end

endmodule

// File: rtl/rotation_amount_finder.sv
// Rotation-amount finder: recovers the rotation applied to num to obtain
// rot by testing one candidate amount per clock, smallest amount first.
module rotation_amount_finder
  import rotation_amount_finder_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] num,
  input  logic [N-1:0] rot,
  input  logic         LR,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [M-1:0] amt
);

  localparam logic [M-1:0] LAST_CNT = M'(N - 1);

  state_e       state_q, state_d;
  logic [N-1:0] cur_q, cur_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic         dir_q, dir_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
  logic [M-1:0] amt_q, amt_d;

  logic [N-1:0] cur_rot;
  logic         accept;
  logic         match;
  logic         last;

  rotate_one_bit #(.N(N)) u_rot (
    .din  (cur_q),
    .dir  (dir_q),
    .dout (cur_rot)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign match  = (cur_q == tgt_q);
  assign last   = (cnt_q == LAST_CNT);

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      amt_q   <= amt_d;
    end
  end

  // Next-state logic: search ends on a hit or after the last candidate.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH:  if (match || last) state_d = DONE;
      DONE:    state_d = start ? SEARCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    found_d = found_q;
    amt_d   = amt_q;
    if (accept) begin
      // Capture the operands once; later input changes are ignored.
      cur_d   = num;
      tgt_d   = rot;
      dir_d   = LR;
      cnt_d   = '0;
      found_d = 1'b0;
      amt_d   = '0;
    end else if (state_q == SEARCH) begin
      if (match) begin
        amt_d   = cnt_q;
        found_d = 1'b1;
        done_d  = 1'b1;
      end else if (last) begin
        amt_d   = '0;
        found_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        // Another candidate is still to be tested, so stay busy.
        cur_d  = cur_rot;
        cnt_d  = cnt_q + M'(1);
        busy_d = 1'b1;
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign amt   = amt_q;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Directed bench for the rotation-amount finder: a vector table plus
// hand-written sequences for restart, ignored start and mid-search reset.
module tb_rotation_amount_finder;

  localparam int N = 16;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] num = '0;
  logic [N-1:0] rot = '0;
  logic         lr = 1'b0;
  logic         busy, done, found;
  logic [M-1:0] amt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0_cyc = 0;
  logic [N-1:0] cap_num, cap_rot;
  logic         cap_lr;

  typedef struct {
    logic [15:0] num;
    logic [15:0] rot;
    logic        lr;
    logic        exp_found;
    int          exp_amt;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  rotation_amount_finder #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .num   (num),
    .rot   (rot),
    .LR    (lr),
    .busy  (busy),
    .done  (done),
    .found (found),
    .amt   (amt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference rotator, same behaviour as the barrel shifter.
  function automatic logic [15:0] ref_rot(input logic [15:0] v, input int k, input logic left);
    logic [31:0] d;
    d = {v, v};
    if (left) begin
      d = d << k;
      return d[31:16];
    end else begin
      d = d >> k;
      return d[15:0];
    end
  endfunction

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic start_search(input logic [15:0] n, input logic [15:0] r, input logic l);
    @(negedge clk);
    num = n; rot = r; lr = l; start = 1'b1;
    cap_num = n; cap_rot = r; cap_lr = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0_cyc = cyc;
  endtask

  // Waits (bounded) for done, returns latency from T0, found, amt and the
  // number of busy cycles seen before done.
  task automatic wait_done(output int lat, output logic f, output int a, output int bcnt);
    logic seen;
    seen = 1'b0;
    bcnt = 0;
    lat = -1; f = 1'b0; a = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0_cyc;
        f    = found;
        a    = int'(amt);
        check("busy_low_at_done", int'(busy), 0);
        if (found) check("shifter_invariant", int'(ref_rot(cap_num, int'(amt), cap_lr)), int'(cap_rot));
      end else if (busy) begin
        bcnt++;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_pulse_end();
    @(posedge clk);
    #1;
    check("done_single_cycle", int'(done), 0);
  endtask

  int lat, a, b;
  logic f;
  int done_seen;

  initial begin
    vecs[0] = '{16'hFF00, 16'h1FE0, 1'b0, 1'b1, 3, 4};
    vecs[1] = '{16'hFF00, 16'hE01F, 1'b1, 1'b1, 5, 6};
    vecs[2] = '{16'hFF00, 16'h0001, 1'b0, 1'b0, 0, 16};
    vecs[3] = '{16'hAAAA, 16'h5555, 1'b0, 1'b1, 1, 2};
    vecs[4] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 0, 1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1};
    vecs[6] = '{16'h8001, 16'h0003, 1'b1, 1'b1, 1, 2};
    vecs[7] = '{16'h0001, 16'h8000, 1'b1, 1'b1, 15, 16};
    vecs[8] = '{16'h0001, 16'h8000, 1'b0, 1'b1, 1, 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_amt", int'(amt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      start_search(vecs[i].num, vecs[i].rot, vecs[i].lr);
      check("t0_found_cleared", int'(found), 0);
      check("t0_amt_cleared", int'(amt), 0);
      wait_done(lat, f, a, b);
      $display("vec %0d num=%h rot=%h lr=%0d -> found=%0d amt=%0d lat=%0d busy=%0d",
               i, vecs[i].num, vecs[i].rot, vecs[i].lr, f, a, lat, b);
      check("latency", lat, vecs[i].exp_lat);
      check("found", int'(f), int'(vecs[i].exp_found));
      check("amt", a, vecs[i].exp_amt);
      check("busy_cycles", b, vecs[i].exp_lat - 1);
      check_pulse_end();
      check("result_held_found", int'(found), int'(vecs[i].exp_found));
      check("result_held_amt", int'(amt), vecs[i].exp_amt);
    end

    // Start held during SEARCH (with changed operands) is ignored; still
    // high in the DONE cycle, it launches the next search immediately.
    start_search(16'hFF00, 16'h1FE0, 1'b0);
    num = 16'h1234; rot = 16'h1234; lr = 1'b1; start = 1'b1;
    wait_done(lat, f, a, b);
    $display("ignore-start: found=%0d amt=%0d lat=%0d", f, a, lat);
    check("ign_latency", lat, 4);
    check("ign_amt", a, 3);
    check("ign_found", int'(f), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0_cyc = cyc;
    cap_num = 16'h1234; cap_rot = 16'h1234; cap_lr = 1'b1;
    check("b2b_done_dropped", int'(done), 0);
    check("b2b_found_cleared", int'(found), 0);
    wait_done(lat, f, a, b);
    $display("restart-in-done: found=%0d amt=%0d lat=%0d", f, a, lat);
    check("b2b_latency", lat, 1);
    check("b2b_amt", a, 0);
    check("b2b_found", int'(f), 1);

    // A further start driven inside the DONE cycle.
    start_search(16'hAAAA, 16'h5555, 1'b0);
    wait_done(lat, f, a, b);
    $display("b2b-2: found=%0d amt=%0d lat=%0d", f, a, lat);
    check("b2b2_latency", lat, 2);
    check("b2b2_amt", a, 1);
    check_pulse_end();

    // Sweep every amount in both directions for num = FF00.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        start_search(16'hFF00, ref_rot(16'hFF00, k, d[0]), d[0]);
        wait_done(lat, f, a, b);
        $display("sweep lr=%0d k=%0d -> found=%0d amt=%0d lat=%0d", d, k, f, a, lat);
        check("sweep_found", int'(f), 1);
        check("sweep_amt", a, k);
        check("sweep_latency", lat, k + 1);
        check_pulse_end();
      end
    end

    // Reset mid-search at cnt = 7 aborts without a done pulse.
    start_search(16'hFF00, 16'h0001, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("mid-search reset: busy=%0d done=%0d found=%0d amt=%0d", busy, done, found, amt);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_found", int'(found), 0);
    check("abort_amt", int'(amt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
